// File: rtl/led_ring_pkg.sv
// rtl/led_ring_pkg.sv - shared types and constants for the LED ring sequencer
// Contents: mode_t (switch encoding), state_t (sequencer FSM), dir_t (bounce
// direction), LED_RESET_PAT (lsb one-hot pattern, sliced to N_LEDS by users).
package led_ring_pkg;

  typedef enum logic [1:0] {
    ROT_L  = 2'b00,
    ROT_R  = 2'b01,
    BOUNCE = 2'b10,
    STEP_M = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10
  } state_t;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

  localparam logic [31:0] LED_RESET_PAT = 32'd1;

endpackage

// File: rtl/led_ring_ctrl_if.sv
// rtl/led_ring_ctrl_if.sv - switch/button inputs and LED outputs of the ring sequencer
// Signals: enable, mode, step_btn (board side -> sequencer);
//          led, pos, tick, err (sequencer -> pins).
// Modports: master = board/driver side, slave = led_ring_ctrl.
interface led_ring_ctrl_if
  import led_ring_pkg::*;
#(
  parameter int N_LEDS = 4
);
  localparam int POS_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

  logic              enable;
  mode_t             mode;
  logic              step_btn;
  logic [N_LEDS-1:0] led;
  logic [POS_W-1:0]  pos;
  logic              tick;
  logic              err;

  modport master (output enable, mode, step_btn, input led, pos, tick, err);
  modport slave  (input enable, mode, step_btn, output led, pos, tick, err);
endinterface

// File: rtl/ring_tick_prescaler.sv
// rtl/ring_tick_prescaler.sv - advance-rate prescaler for the LED ring
// Ports: clk (rising edge), sw (async active-high reset), run (count enable,
//        count cleared while low), tick_int (high in the last count cycle).
module ring_tick_prescaler #(
  parameter int CLK_DIV = 1250000
) (
  input  logic clk,
  input  logic sw,
  input  logic run,
  output logic tick_int
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // With CLK_DIV=1, LAST is 0 and the count never leaves 0: a tick every run cycle.
  assign tick_int = run && (cnt_q == LAST);

  always_comb begin
    cnt_d = '0;
    if (run && (cnt_q != LAST)) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge sw) begin
    if (sw) cnt_q <= '0;
    else    cnt_q <= cnt_d;
  end
endmodule

// File: rtl/led_ring_ctrl.sv
// rtl/led_ring_ctrl.sv - one-hot LED ring sequencer (rotate/bounce/manual step)
// Ports: clk (rising edge), sw (async active-high reset),
//        bus (led_ring_ctrl_if.slave: enable, mode, step_btn in; led, pos, tick, err out).
// Option: LED_RING_ONEHOT_CHECK_EN adds a one-hot checker with sticky err;
//         without it err is tied to 0.
module led_ring_ctrl
  import led_ring_pkg::*;
#(
  parameter int N_LEDS  = 4,
  parameter int CLK_DIV = 1250000
) (
  input  logic              clk,
  input  logic              sw,
  led_ring_ctrl_if.slave    bus
);
  localparam int POS_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
  localparam logic [N_LEDS-1:0] RESET_PAT = LED_RESET_PAT[N_LEDS-1:0];

  state_t            state_q, state_d;
  dir_t              dir_q, dir_d;
  logic [N_LEDS-1:0] led_q, led_d;
  logic              tick_q, tick_d;
  logic [2:0]        sync_q;
  logic              tick_int;
  logic              step_edge;
  logic              eff_up;
  logic [N_LEDS-1:0] shl, shr, bnc;
  logic [POS_W-1:0]  pos_v;

  ring_tick_prescaler #(.CLK_DIV(CLK_DIV)) u_presc (
    .clk      (clk),
    .sw       (sw),
    .run      (state_q == RUN),
    .tick_int (tick_int)
  );

  // [0],[1] synchronize the raw button, [2] holds the previous synced level.
  // It runs in every state so an edge seen outside STEP is already consumed.
  assign step_edge = sync_q[1] & ~sync_q[2];

  assign shl = {led_q[N_LEDS-2:0], led_q[N_LEDS-1]};
  assign shr = {led_q[0], led_q[N_LEDS-1:1]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.enable) state_d = (bus.mode == STEP_M) ? STEP : RUN;
      RUN:     if (!bus.enable) state_d = IDLE;
               else if (bus.mode == STEP_M) state_d = STEP;
      STEP:    if (!bus.enable) state_d = IDLE;
               else if (bus.mode != STEP_M) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Bounce: an end LED always turns the walk around, even if dir was left
  // pointing outward by a previous rotate mode.
  always_comb begin
    eff_up = ((dir_q == UP) && !led_q[N_LEDS-1]) || ((dir_q == DOWN) && led_q[0]);
    bnc    = eff_up ? shl : shr;
  end

  always_comb begin
    led_d  = led_q;
    dir_d  = dir_q;
    tick_d = 1'b0;
    if (state_d != IDLE) begin
      if ((state_q == STEP) && step_edge) begin
        led_d  = shl;
        tick_d = 1'b1;
      end else if (tick_int) begin
        tick_d = 1'b1;
        case (bus.mode)
          ROT_R:  led_d = shr;
          BOUNCE: begin
            led_d = bnc;
            if (bnc[N_LEDS-1])  dir_d = DOWN;
            else if (bnc[0])    dir_d = UP;
            else                dir_d = eff_up ? UP : DOWN;
          end
          default: led_d = shl;
        endcase
      end
    end
`ifdef LED_RING_ONEHOT_CHECK_EN
    // x & (x-1) clears the lowest set bit; zero result on non-zero x means one-hot.
    if ((led_q == '0) || ((led_q & (led_q - RESET_PAT)) != '0)) led_d = RESET_PAT;
`endif
  end

  always_comb begin
    pos_v = '0;
    for (int i = 0; i < N_LEDS; i++) if (led_q[i]) pos_v = POS_W'(i);
  end

  always_ff @(posedge clk or posedge sw) begin
    if (sw) begin
      state_q <= IDLE;
      dir_q   <= UP;
      led_q   <= RESET_PAT;
      tick_q  <= 1'b0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      led_q   <= led_d;
      tick_q  <= tick_d;
      sync_q  <= {sync_q[1:0], bus.step_btn};
    end
  end

`ifdef LED_RING_ONEHOT_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or posedge sw) begin
    if (sw) err_q <= 1'b0;
    else if ((led_q == '0) || ((led_q & (led_q - RESET_PAT)) != '0)) err_q <= 1'b1;
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.led  = led_q;
  assign bus.pos  = pos_v;
  assign bus.tick = tick_q;
endmodule

// File: tb/tb_led_ring_ctrl.sv
// tb/tb_led_ring_ctrl.sv - directed self-checking bench for led_ring_ctrl (N_LEDS=4, CLK_DIV=4)
module tb_led_ring_ctrl;
  import led_ring_pkg::*;

  logic clk = 1'b0;
  logic sw  = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  led_ring_ctrl_if #(.N_LEDS(4)) bus ();

  led_ring_ctrl #(.N_LEDS(4), .CLK_DIV(4)) dut (
    .clk (clk),
    .sw  (sw),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    sw = 1'b1;
    cyc(1);
    sw = 1'b0;
  endtask

  // One RUN advance with CLK_DIV=4: three quiet cycles, then the new pattern with tick.
  task automatic step_chk(input string tag, input logic [3:0] prev, input logic [3:0] nxt, input int p);
    cyc(3);
    check({tag, " hold led"}, 32'(bus.led), 32'(prev));
    check({tag, " hold tick"}, 32'(bus.tick), 32'd0);
    cyc(1);
    check({tag, " led"}, 32'(bus.led), 32'(nxt));
    check({tag, " pos"}, 32'(bus.pos), 32'(p));
    check({tag, " tick"}, 32'(bus.tick), 32'd1);
  endtask

  logic [3:0] rl_seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] bn_seq [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
  int         bn_pos [7] = '{1, 2, 3, 2, 1, 0, 1};
  logic [3:0] st_seq [3] = '{4'b0010, 4'b0100, 4'b1000};

  initial begin
    logic [3:0] prev;
    bus.enable   = 1'b0;
    bus.mode     = ROT_L;
    bus.step_btn = 1'b0;
    cyc(2);
    check("rst led", 32'(bus.led), 32'h1);
    check("rst pos", 32'(bus.pos), 32'd0);
    check("rst tick", 32'(bus.tick), 32'd0);
    check("rst err", 32'(bus.err), 32'd0);

    // Rotate left
    sw = 1'b0;
    bus.enable = 1'b1;
    cyc(1);
    prev = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      step_chk($sformatf("rotl%0d", i), prev, rl_seq[i], (i + 1) % 4);
      prev = rl_seq[i];
    end

    // Bounce from reset
    bus.mode = BOUNCE;
    do_reset();
    cyc(1);
    prev = 4'b0001;
    for (int i = 0; i < 7; i++) begin
      step_chk($sformatf("bounce%0d", i), prev, bn_seq[i], bn_pos[i]);
      prev = bn_seq[i];
    end

    // Manual step: 3 clk from pin edge to led
    bus.mode = STEP_M;
    do_reset();
    cyc(1);
    prev = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      bus.step_btn = 1'b1;
      cyc(2);
      check($sformatf("step%0d early", i), 32'(bus.led), 32'(prev));
      cyc(1);
      check($sformatf("step%0d led", i), 32'(bus.led), 32'(st_seq[i]));
      check($sformatf("step%0d tick", i), 32'(bus.tick), 32'd1);
      bus.step_btn = 1'b0;
      cyc(3);
      check($sformatf("step%0d settle", i), 32'(bus.led), 32'(st_seq[i]));
      prev = st_seq[i];
    end

    // Button edge while rotating gives no extra advance; no stale edge on STEP re-entry
    bus.mode     = ROT_L;
    bus.step_btn = 1'b1;
    cyc(4);
    check("discard hold", 32'(bus.led), 32'b1000);
    check("discard tick", 32'(bus.tick), 32'd0);
    cyc(1);
    check("discard adv", 32'(bus.led), 32'b0001);
    bus.step_btn = 1'b0;
    bus.mode     = STEP_M;
    cyc(4);
    check("stale led", 32'(bus.led), 32'b0001);
    check("stale tick", 32'(bus.tick), 32'd0);

    // Drop enable in the tick_int cycle
    bus.mode = ROT_L;
    do_reset();
    cyc(1);
    step_chk("pre0", 4'b0001, 4'b0010, 1);
    step_chk("pre1", 4'b0010, 4'b0100, 2);
    cyc(3);
    check("drop tick_int", 32'(dut.u_presc.tick_int), 32'd1);
    bus.enable = 1'b0;
    cyc(1);
    check("drop led", 32'(bus.led), 32'b0100);
    check("drop tick", 32'(bus.tick), 32'd0);
    check("drop presc", 32'(dut.u_presc.cnt_q), 32'd0);
    cyc(4);
    check("idle led", 32'(bus.led), 32'b0100);
    bus.enable = 1'b1;
    cyc(1);
    step_chk("reen", 4'b0100, 4'b1000, 3);

    // Async reset between edges, while tick is high
    #2 sw = 1'b1;
    #1;
    check("async led", 32'(bus.led), 32'h1);
    check("async pos", 32'(bus.pos), 32'd0);
    check("async tick", 32'(bus.tick), 32'd0);
    @(negedge clk);
    bus.enable = 1'b0;
    sw = 1'b0;
    cyc(1);

`ifdef LED_RING_ONEHOT_CHECK_EN
    force dut.led_q = 4'b0110;
    #1 release dut.led_q;
    cyc(1);
    check("chk led", 32'(bus.led), 32'b0001);
    check("chk err", 32'(bus.err), 32'd1);
    cyc(3);
    check("chk err sticky", 32'(bus.err), 32'd1);
    do_reset();
    check("chk err clr", 32'(bus.err), 32'd0);
`else
    check("err tied", 32'(bus.err), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
